instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of the microcoded controller. It holds the program counter, fetches one instruction word from instruction memory over a req/ack handshake, and presents it on the `IR` bus that the controller's mapping function decodes. Fetch and PC-load commands come from control-word bits of the controller's `OPs` output. `busy` and `ir_valid` flags let the microcode wait for the fetch to complete.

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port of the fetch stage.
// The fetch unit is the master: it raises a request with an address and
// holds both steady until the memory answers with an acknowledge and the
// instruction word in the same cycle.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 8,
   parameter int IR_W   = 16
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [IR_W-1:0]   imem_rdata;

   // Fetch unit side
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   // Instruction memory side
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage feeding the microcoded controller.
// Holds the program counter and fetches one instruction word per request
// from instruction memory into IR.
// Microcode asks for work through two control-word bits:
//   - fetch:   start a fetch at the current PC
//   - pc_load: replace the PC with pc_in
// It then waits on busy / ir_valid for the fetch to finish.
module instr_fetch_unit #(
   parameter int ADDR_W   = 8,
   parameter int IR_W     = 16,
   parameter int RESET_PC = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fetch,
   input  logic                pc_load,
   input  logic [ADDR_W-1:0]   pc_in,
   instr_fetch_unit_if.master  imem,
   output logic [IR_W-1:0]     IR,
   output logic [ADDR_W-1:0]   pc,
   output logic                busy,
   output logic                ir_valid
);

   localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q,    pc_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [IR_W-1:0]   ir_q,    ir_d;
   logic              req_q,   req_d;
   logic              valid_q, valid_d;

   // Next-state decode.
   // Commands are only honoured in IDLE, and the memory answer only in WAIT.
   // That makes a stray or late acknowledge harmless, and means commands
   // issued while a fetch is outstanding are simply dropped (no queueing).
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      ir_d    = ir_q;
      req_d   = req_q;
      valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pc_load) begin
               pc_d = pc_in;
            end
            if (fetch) begin
               // A same-cycle load wins, so load+fetch fetches from the jump target.
               addr_d  = pc_load ? pc_in : pc_q;
               req_d   = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (imem.imem_ack) begin
               // PC becomes the address just fetched plus one.
               // Natural overflow gives the wrap from all-ones back to zero.
               ir_d    = imem.imem_rdata;
               pc_d    = addr_q + ADDR_W'(1);
               req_d   = 1'b0;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State register for the fetch FSM and all of its registered outputs.
   // Reset is checked first, so it aborts an outstanding fetch: an
   // acknowledge arriving on the same edge is discarded.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC_V;
         addr_q  <= RESET_PC_V;
         ir_q    <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         req_q   <= req_d;
         valid_q <= valid_d;
      end
   end

   // busy is the only output decoded directly from state.
   // This lets microcode see the fetch as outstanding from the issuing edge.
   assign busy           = (state_q == ST_WAIT);
   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign IR             = ir_q;
   assign pc             = pc_q;
   assign ir_valid       = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Every completed fetch is predicted into a scoreboard when its acknowledge
// is driven, and retired when the DUT pulses ir_valid.
module tb_instr_fetch_unit;

   localparam int ADDR_W = 8;
   localparam int IR_W   = 16;

   typedef struct packed {
      logic [IR_W-1:0]   ir;
      logic [ADDR_W-1:0] pc;
   } expect_t;

   logic              clk;
   logic              reset;
   logic              fetch;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_in;
   logic [IR_W-1:0]   IR;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              ir_valid;

   instr_fetch_unit_if #(.ADDR_W(ADDR_W), .IR_W(IR_W)) imem ();

   instr_fetch_unit #(
      .ADDR_W   (ADDR_W),
      .IR_W     (IR_W),
      .RESET_PC (0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .fetch    (fetch),
      .pc_load  (pc_load),
      .pc_in    (pc_in),
      .imem     (imem.master),
      .IR       (IR),
      .pc       (pc),
      .busy     (busy),
      .ir_valid (ir_valid)
   );

   int      checks = 0;
   int      errors = 0;
   expect_t sbQueue[$];

   // Free-running clock with rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it when the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives the control word and the memory response for the next edge.
   task automatic applyStimulus(input logic f, input logic ld, input logic [ADDR_W-1:0] tgt,
                                input logic ack, input logic [IR_W-1:0] data);
      fetch           = f;
      pc_load         = ld;
      pc_in           = tgt;
      imem.imem_ack   = ack;
      imem.imem_rdata = data;
   endtask

   // Advances to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Retires one prediction whenever the DUT announces a new IR.
   always @(negedge clk) begin
      if (ir_valid === 1'b1) begin
         if (sbQueue.size() == 0) begin
            checkOutput("sbUnexpectedValid", 32'(ir_valid), 32'd0);
         end else begin
            expect_t e;
            e = sbQueue.pop_front();
            checkOutput("sbIR", 32'(IR), 32'(e.ir));
            checkOutput("sbPC", 32'(pc), 32'(e.pc));
         end
      end
   end

   // Main stimulus sequence.
   initial begin
      expect_t e;
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      step();
      step();

      $display("[TB] reset values");
      checkOutput("rstPC",    32'(pc),             32'd0);
      checkOutput("rstIR",    32'(IR),             32'd0);
      checkOutput("rstReq",   32'(imem.imem_req),  32'd0);
      checkOutput("rstAddr",  32'(imem.imem_addr), 32'd0);
      checkOutput("rstBusy",  32'(busy),           32'd0);
      checkOutput("rstValid", 32'(ir_valid),       32'd0);
      reset = 1'b1;
      step();

      $display("[TB] single fetch, one-cycle ack");
      applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
      step();
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'hA5C3);
      e.ir = 16'hA5C3; e.pc = 8'h01; sbQueue.push_back(e);
      checkOutput("f1Req",  32'(imem.imem_req),  32'd1);
      checkOutput("f1Addr", 32'(imem.imem_addr), 32'd0);
      checkOutput("f1Busy", 32'(busy),           32'd1);
      step();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      checkOutput("f1DoneIR",    32'(IR),            32'hA5C3);
      checkOutput("f1DonePC",    32'(pc),            32'd1);
      checkOutput("f1DoneValid", 32'(ir_valid),      32'd1);
      checkOutput("f1DoneReq",   32'(imem.imem_req), 32'd0);
      checkOutput("f1DoneBusy",  32'(busy),          32'd0);

      // A spurious ack while idle must change nothing.
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'hDEAD);
      step();
      checkOutput("f1ValidPulse", 32'(ir_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      step();
      checkOutput("idleAckIR",    32'(IR),       32'hA5C3);
      checkOutput("idleAckValid", 32'(ir_valid), 32'd0);
      checkOutput("idleAckBusy",  32'(busy),     32'd0);

      $display("[TB] fetch with 5-cycle ack delay, ignored commands");
      applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
      step();
      for (int i = 0; i < 5; i++) begin
         checkOutput("waitReq",  32'(imem.imem_req),  32'd1);
         checkOutput("waitAddr", 32'(imem.imem_addr), 32'd1);
         checkOutput("waitBusy", 32'(busy),           32'd1);
         checkOutput("waitPC",   32'(pc),             32'd1);
         if (i == 1) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
         end else if (i == 2) begin
            applyStimulus(1'b0, 1'b1, 8'h40, 1'b0, '0);
         end else if (i == 4) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'h1234);
            e.ir = 16'h1234; e.pc = 8'h02; sbQueue.push_back(e);
         end else begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
         end
         step();
      end
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      checkOutput("slowIR", 32'(IR), 32'h1234);
      checkOutput("slowPC", 32'(pc), 32'd2);
      step();
      checkOutput("slowNoRefetch", 32'(imem.imem_req), 32'd0);

      $display("[TB] load and fetch together at top of address space");
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0, '0);
      step();
      checkOutput("wrapAddr", 32'(imem.imem_addr), 32'hFF);
      checkOutput("wrapLdPC", 32'(pc),             32'hFF);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'h5A5A);
      e.ir = 16'h5A5A; e.pc = 8'h00; sbQueue.push_back(e);
      step();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      checkOutput("wrapPC", 32'(pc), 32'd0);
      checkOutput("wrapIR", 32'(IR), 32'h5A5A);
      step();

      $display("[TB] reset during outstanding fetch");
      reset = 1'b0;
      step();
      reset = 1'b1;
      checkOutput("rst2IR", 32'(IR), 32'd0);
      applyStimulus(1'b1, 1'b1, 8'h33, 1'b0, '0);
      step();
      checkOutput("abortPre", 32'(pc), 32'h33);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'hBEEF);
      reset = 1'b0;
      step();
      reset = 1'b1;
      checkOutput("abortIR",    32'(IR),             32'd0);
      checkOutput("abortPC",    32'(pc),             32'd0);
      checkOutput("abortReq",   32'(imem.imem_req),  32'd0);
      checkOutput("abortAddr",  32'(imem.imem_addr), 32'd0);
      checkOutput("abortBusy",  32'(busy),           32'd0);
      checkOutput("abortValid", 32'(ir_valid),       32'd0);
      step();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
      checkOutput("lateAckIR",    32'(IR),       32'd0);
      checkOutput("lateAckPC",    32'(pc),       32'd0);
      checkOutput("lateAckValid", 32'(ir_valid), 32'd0);
      checkOutput("lateAckBusy",  32'(busy),     32'd0);

      $display("[TB] back-to-back fetches with immediate ack");
      applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
      step();
      for (int f = 0; f < 3; f++) begin
         checkOutput("b2bBusy", 32'(busy),           32'd1);
         checkOutput("b2bAddr", 32'(imem.imem_addr), 32'(f));
         applyStimulus(1'b1, 1'b0, '0, 1'b1, IR_W'(16'h1000 + f));
         e.ir = IR_W'(16'h1000 + f); e.pc = ADDR_W'(f + 1); sbQueue.push_back(e);
         step();
         checkOutput("b2bDonePC",    32'(pc),       32'(f + 1));
         checkOutput("b2bDoneValid", 32'(ir_valid), 32'd1);
         checkOutput("b2bDoneBusy",  32'(busy),     32'd0);
         applyStimulus((f < 2) ? 1'b1 : 1'b0, 1'b0, '0, 1'b0, '0);
         step();
         checkOutput("b2bValidLow", 32'(ir_valid), 32'd0);
         checkOutput("b2bReissue",  32'(busy),     (f < 2) ? 32'd1 : 32'd0);
      end
      step();

      checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
